// File: rtl/store_buffer.sv
// Circular store buffer: captures finished stores, forwards to loads, kills on mispredict,
// drains committed stores to memory. Optional STORE_BUFFER_STATS_EN adds perf counters.
module store_buffer #(
    parameter int DEPTH       = 32,
    parameter int SB_SEL      = 5,
    parameter int ADDR_LEN    = 32,
    parameter int DATA_LEN    = 32,
    parameter int SPECTAG_LEN = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stfin,
    input  logic [ADDR_LEN-1:0]    storeaddr,
    input  logic [DATA_LEN-1:0]    storedata,
    input  logic [SPECTAG_LEN-1:0] stspectag,
    input  logic                   stspecbit,
    output logic                   fullsb,
    input  logic [ADDR_LEN-1:0]    ldaddr,
    output logic                   hitsb,
    output logic [DATA_LEN-1:0]    lddatasb,
    input  logic [1:0]             stcom,
    input  logic                   prsuccess,
    input  logic                   prmiss,
    input  logic [SPECTAG_LEN-1:0] spectagfix,
    input  logic                   memoccupy_ld,
    output logic                   memwe,
    output logic [ADDR_LEN-1:0]    memaddr,
    output logic [DATA_LEN-1:0]    memdata
`ifdef STORE_BUFFER_STATS_EN
    ,
    output logic [31:0]            perf_fwdhit,
    output logic [31:0]            perf_fullcyc
`endif
);

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [DEPTH-1:0]       committed_q, committed_d;
    logic [DEPTH-1:0]       specbit_q, specbit_d;
    logic [SPECTAG_LEN-1:0] spectag_q [DEPTH];
    logic [SPECTAG_LEN-1:0] spectag_d [DEPTH];
    logic [ADDR_LEN-1:0]    addr_q [DEPTH];
    logic [ADDR_LEN-1:0]    addr_d [DEPTH];
    logic [DATA_LEN-1:0]    data_q [DEPTH];
    logic [DATA_LEN-1:0]    data_d [DEPTH];
    logic [SB_SEL-1:0]      head_q, head_d, comptr_q, comptr_d, tail_q, tail_d;
    logic [SB_SEL:0]        count_q, count_d;

    logic              full, drain, alloc;
    logic [DEPTH-1:0]  kill;
    logic [SB_SEL:0]   nkill;
    logic [SB_SEL-1:0] idx;

    assign full  = (count_q == (SB_SEL+1)'(DEPTH));
    assign drain = valid_q[head_q] & committed_q[head_q] & ~memoccupy_ld;
    // prmiss gates allocation: the exunit kills its own in-flight store
    assign alloc = stfin & ~full & ~prmiss;

    always_comb begin
        kill  = '0;
        nkill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = prmiss & valid_q[i] & ~committed_q[i] & specbit_q[i]
                      & (|(spectag_q[i] & spectagfix));
            nkill   = nkill + (SB_SEL+1)'(kill[i]);
        end
    end

    always_comb begin
        valid_d     = valid_q;
        committed_d = committed_q;
        specbit_d   = specbit_q;
        spectag_d   = spectag_q;
        addr_d      = addr_q;
        data_d      = data_q;
        head_d      = head_q;
        comptr_d    = comptr_q + SB_SEL'(stcom);
        tail_d      = tail_q;
        count_d     = count_q - nkill;

        if (drain) begin
            valid_d[head_q]     = 1'b0;
            committed_d[head_q] = 1'b0;
            head_d              = head_q + 1'b1;
            count_d             = count_d - 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (i < int'(stcom))
                committed_d[comptr_q + SB_SEL'(i)] = 1'b1;
        end
        if (prsuccess) begin
            for (int i = 0; i < DEPTH; i++)
                if (valid_q[i] && (spectag_q[i] & spectagfix) != '0)
                    specbit_d[i] = 1'b0;
        end
        // killed entries are the youngest run, so tail simply backs up by their count
        if (prmiss) begin
            valid_d = valid_d & ~kill;
            tail_d  = tail_q - nkill[SB_SEL-1:0];
        end
        if (alloc) begin
            valid_d[tail_q]     = 1'b1;
            committed_d[tail_q] = 1'b0;
            specbit_d[tail_q]   = stspecbit;
            spectag_d[tail_q]   = stspectag;
            addr_d[tail_q]      = storeaddr;
            data_d[tail_q]      = storedata;
            tail_d              = tail_q + 1'b1;
            count_d             = count_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q     <= '0;
            committed_q <= '0;
            specbit_q   <= '0;
            head_q      <= '0;
            comptr_q    <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            specbit_q   <= specbit_d;
            head_q      <= head_d;
            comptr_q    <= comptr_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
        spectag_q <= spectag_d;
        addr_q    <= addr_d;
        data_q    <= data_d;
    end

    // Walk oldest to youngest so the last match wins
    always_comb begin
        hitsb    = 1'b0;
        lddatasb = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + SB_SEL'(i);
            if (reset && valid_q[idx] && addr_q[idx] == ldaddr) begin
                hitsb    = 1'b1;
                lddatasb = data_q[idx];
            end
        end
    end

    always_comb begin
        fullsb  = reset & full;
        memwe   = reset & drain;
        memaddr = (reset && valid_q[head_q]) ? addr_q[head_q] : '0;
        memdata = (reset && valid_q[head_q]) ? data_q[head_q] : '0;
    end

`ifdef STORE_BUFFER_STATS_EN
    logic [31:0] perf_fwdhit_q, perf_fwdhit_d, perf_fullcyc_q, perf_fullcyc_d;

    always_comb begin
        perf_fwdhit_d  = perf_fwdhit_q;
        perf_fullcyc_d = perf_fullcyc_q;
        if (hitsb && perf_fwdhit_q != '1)
            perf_fwdhit_d = perf_fwdhit_q + 1'b1;
        if (fullsb && perf_fullcyc_q != '1)
            perf_fullcyc_d = perf_fullcyc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fwdhit_q  <= '0;
            perf_fullcyc_q <= '0;
        end else begin
            perf_fwdhit_q  <= perf_fwdhit_d;
            perf_fullcyc_q <= perf_fullcyc_d;
        end
    end

    assign perf_fwdhit  = perf_fwdhit_q;
    assign perf_fullcyc = perf_fullcyc_q;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: queue-based reference model checked every cycle plus directed literal checks.
module tb_store_buffer;
    logic        clk = 0, reset = 0;
    logic        stfin = 0, stspecbit = 0, prsuccess = 0, prmiss = 0, memoccupy_ld = 0;
    logic [31:0] storeaddr = 0, storedata = 0, ldaddr = 0;
    logic [4:0]  stspectag = 0, spectagfix = 0;
    logic [1:0]  stcom = 0;
    logic        fullsb, hitsb, memwe;
    logic [31:0] lddatasb, memaddr, memdata;
`ifdef STORE_BUFFER_STATS_EN
    logic [31:0] perf_fwdhit, perf_fullcyc;
`endif

    store_buffer dut (
        .clk(clk), .reset(reset), .stfin(stfin), .storeaddr(storeaddr), .storedata(storedata),
        .stspectag(stspectag), .stspecbit(stspecbit), .fullsb(fullsb), .ldaddr(ldaddr),
        .hitsb(hitsb), .lddatasb(lddatasb), .stcom(stcom), .prsuccess(prsuccess),
        .prmiss(prmiss), .spectagfix(spectagfix), .memoccupy_ld(memoccupy_ld),
        .memwe(memwe), .memaddr(memaddr), .memdata(memdata)
`ifdef STORE_BUFFER_STATS_EN
        , .perf_fwdhit(perf_fwdhit), .perf_fullcyc(perf_fullcyc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  t;
        logic        s;
        logic        c;
    } ent_t;

    ent_t sb[$];
    int   checks = 0, errors = 0;
    int   wr_cnt = 0;
    logic wrap_ph = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered queue, oldest at index 0
    always @(posedge clk) begin
        int  nunc, first;
        bit  drn, full;
        if (!reset) begin
            sb.delete();
        end else begin
            full = (sb.size() == 32);
            drn  = (sb.size() > 0) && sb[0].c && !memoccupy_ld;
            nunc = 0;
            first = -1;
            for (int i = 0; i < sb.size(); i++)
                if (!sb[i].c) begin
                    nunc++;
                    if (first < 0) first = i;
                end
            assert (int'(stcom) <= nunc) else begin
                errors++;
                $display("FAIL stcom_overflow actual=%0d expected<=%0d", stcom, nunc);
            end
            for (int k = 0; k < int'(stcom) && k < nunc; k++) sb[first+k].c = 1;
            if (prsuccess)
                for (int i = 0; i < sb.size(); i++)
                    if ((sb[i].t & spectagfix) != 0) sb[i].s = 0;
            if (prmiss)
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (!sb[i].c && sb[i].s && (sb[i].t & spectagfix) != 0) sb.delete(i);
            if (drn) void'(sb.pop_front());
            if (stfin && !full && !prmiss)
                sb.push_back('{a: storeaddr, d: storedata, t: stspectag, s: stspecbit, c: 0});
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        logic        e_full, e_hit, e_we;
        logic [31:0] e_ld, e_ma, e_md;
        e_full = 0; e_hit = 0; e_we = 0; e_ld = 0; e_ma = 0; e_md = 0;
        if (reset) begin
            e_full = (sb.size() == 32);
            if (sb.size() > 0) begin
                e_we = sb[0].c && !memoccupy_ld;
                e_ma = sb[0].a;
                e_md = sb[0].d;
            end
            for (int i = sb.size() - 1; i >= 0; i--)
                if (!e_hit && sb[i].a == ldaddr) begin
                    e_hit = 1;
                    e_ld  = sb[i].d;
                end
        end
        chk("m_fullsb", {31'b0, fullsb}, {31'b0, e_full});
        chk("m_hitsb", {31'b0, hitsb}, {31'b0, e_hit});
        chk("m_lddatasb", lddatasb, e_ld);
        chk("m_memwe", {31'b0, memwe}, {31'b0, e_we});
        chk("m_memaddr", memaddr, e_ma);
        chk("m_memdata", memdata, e_md);
        if (wrap_ph && memwe) wr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic s, input logic [4:0] t);
        stfin = 1; storeaddr = a; storedata = d; stspecbit = s; stspectag = t;
        tick();
        stfin = 0;
    endtask

    initial begin
        // reset with stfin held high
        reset = 0; stfin = 1; storeaddr = 32'h55; storedata = 32'h66;
        tick(); tick();
        reset = 1; stfin = 0; ldaddr = 32'h55;
        #1;
        chk("rst_fullsb", {31'b0, fullsb}, 32'h0);
        chk("rst_memwe", {31'b0, memwe}, 32'h0);
        chk("rst_hitsb", {31'b0, hitsb}, 32'h0);
        chk("rst_memaddr", memaddr, 32'h0);

        // forwarding: youngest match wins
        st(32'h100, 32'h11, 0, 0);
        st(32'h100, 32'h22, 0, 0);
        ldaddr = 32'h100; #1;
        chk("fwd_hit", {31'b0, hitsb}, 32'h1);
        chk("fwd_data", lddatasb, 32'h22);
        ldaddr = 32'h104; #1;
        chk("fwd_miss_hit", {31'b0, hitsb}, 32'h0);
        chk("fwd_miss_data", lddatasb, 32'h0);
        stcom = 2; tick(); stcom = 0;
        chk("drain1_we", {31'b0, memwe}, 32'h1);
        chk("drain1_addr", memaddr, 32'h100);
        chk("drain1_data", memdata, 32'h11);
        tick(); tick(); tick();

        // fill to full, extra store ignored
        for (int i = 0; i < 32; i++) st(32'h1000 + 32'(i) * 4, 32'(i) + 32'h300, 0, 0);
        chk("full_set", {31'b0, fullsb}, 32'h1);
        st(32'hdead, 32'hbeef, 0, 0);
        ldaddr = 32'hdead; #1;
        chk("full_ignored", {31'b0, hitsb}, 32'h0);
        stcom = 2; tick(); stcom = 0;
        chk("full_drain_a", memaddr, 32'h1000);
        chk("full_still", {31'b0, fullsb}, 32'h1);
        tick();
        chk("full_dropped", {31'b0, fullsb}, 32'h0);
        chk("full_drain_b", memaddr, 32'h1004);
        tick();
        chk("full_no3rd", {31'b0, memwe}, 32'h0);
        for (int i = 0; i < 15; i++) begin stcom = 2; tick(); end
        stcom = 0;
        for (int i = 0; i < 35; i++) tick();

        // mispredict kills the speculative tail run; stfin in the same cycle is dropped
        st(32'h200, 32'hA0, 0, 5'b00000);
        st(32'h204, 32'hA1, 1, 5'b00010);
        st(32'h208, 32'hA2, 1, 5'b00010);
        prmiss = 1; spectagfix = 5'b00010; stfin = 1; storeaddr = 32'h2ff; storedata = 32'h9;
        tick();
        prmiss = 0; stfin = 0;
        ldaddr = 32'h204; #1;
        chk("kill_y", {31'b0, hitsb}, 32'h0);
        ldaddr = 32'h2ff; #1;
        chk("kill_stfin", {31'b0, hitsb}, 32'h0);
        ldaddr = 32'h200; #1;
        chk("kill_x_kept", lddatasb, 32'hA0);
        st(32'h20c, 32'hA3, 0, 0);
        stcom = 2; tick(); stcom = 0;
        chk("kill_tail_a", memaddr, 32'h200);
        tick();
        chk("kill_tail_b", memaddr, 32'h20c);
        tick();

        // correct prediction clears specbit so a later miss no longer kills
        st(32'h304, 32'hB1, 1, 5'b00010);
        st(32'h308, 32'hB2, 1, 5'b00010);
        prsuccess = 1; spectagfix = 5'b00010; tick(); prsuccess = 0;
        prmiss = 1; tick(); prmiss = 0;
        ldaddr = 32'h308; #1;
        chk("succ_survive", lddatasb, 32'hB2);
        stcom = 2; tick(); stcom = 0;
        tick(); tick();

        // load holds memory for 3 cycles
        st(32'h400, 32'h44, 0, 0);
        stcom = 1; memoccupy_ld = 1; tick(); stcom = 0;
        for (int i = 0; i < 3; i++) begin
            chk("occ_block", {31'b0, memwe}, 32'h0);
            if (i < 2) tick();
        end
        memoccupy_ld = 0; #1;
        chk("occ_we", {31'b0, memwe}, 32'h1);
        chk("occ_addr", memaddr, 32'h400);
        chk("occ_data", memdata, 32'h44);
        tick();

        // wrap-around streaming
        wrap_ph = 1;
        for (int i = 0; i < 40; i++) begin
            stfin = 1; storeaddr = 32'h5000 + 32'(i) * 4; storedata = 32'hA00 + 32'(i);
            stcom = (i > 0) ? 2'd1 : 2'd0;
            tick();
        end
        stfin = 0; stcom = 1; tick(); stcom = 0;
        for (int i = 0; i < 4; i++) tick();
        wrap_ph = 0;
        chk("wrap_writes", 32'(wr_cnt), 32'd40);
        chk("wrap_empty_we", {31'b0, memwe}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Circular store buffer on the receiving end of the load/store unit's store interface.
- Captures finished stores (address, data, speculation tag) from the ldst exunit and reports back-pressure (fullsb).
- Forwards buffered data to loads (hitsb/lddatasb), discards stores killed by branch mispredicts, and marks stores committed as the ROB retires them.
- Drains committed stores to data memory, one per cycle, whenever the load path is not using memory.

Parameters:
- DEPTH, 32, number of entries (power of two).
- SB_SEL, 5, log2(DEPTH).
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width.
- SPECTAG_LEN, 5, speculation tag mask width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- stfin  in  1  store finished; allocate an entry this cycle.
- storeaddr  in  ADDR_LEN  store effective address.
- storedata  in  DATA_LEN  store data.
- stspectag  in  SPECTAG_LEN  speculation tag of the store.
- stspecbit  in  1  store is speculative.
- fullsb  out  1  buffer full.
- ldaddr  in  ADDR_LEN  load address for forwarding lookup.
- hitsb  out  1  load address matches a buffered entry.
- lddatasb  out  DATA_LEN  forwarded data.
- stcom  in  2  number of stores (0..2) the ROB commits this cycle.
- prsuccess  in  1  branch resolved correctly.
- prmiss  in  1  branch mispredicted.
- spectagfix  in  SPECTAG_LEN  tag of the resolving branch.
- memoccupy_ld  in  1  load is using memory this cycle.
- memwe  out  1  memory write strobe.
- memaddr  out  ADDR_LEN  write address.
- memdata  out  DATA_LEN  write data.

Behaviour:
- Entry state: valid, committed, specbit, spectag, addr, data.
- Pointers: head (oldest), comptr (oldest uncommitted), tail (next free).
- count: number of valid entries, 0..DEPTH, SB_SEL+1 bits.
- Pointer arithmetic is mod DEPTH; wrap-around is seamless.

Reset (reset==0 at posedge):
- All valid, committed and specbit bits cleared; head, comptr and tail set to 0; count set to 0.
- Outputs during and after reset: fullsb=0, hitsb=0, lddatasb=0, memwe=0, memaddr=0, memdata=0.
- Reset overrides every other input in the same cycle, including mid-drain or mid-allocation.

Allocation:
- stfin & ~fullsb writes the entry at tail: valid=1, committed=0, addr, data, spectag, specbit. tail advances by 1.
- stfin while full is ignored; the exunit never issues a store while full.
- stfin & prmiss in the same cycle: allocation is suppressed, because the exunit itself gates stfin on its own kill.

fullsb:
- Combinational from the registered count: fullsb = (count == DEPTH).
- The same-cycle drain is not counted.

Commit:
- stcom = k marks the k entries starting at comptr as committed; comptr advances by k.
- Commit target is never speculative.
- stcom exceeding the number of uncommitted valid entries is a protocol error; a bench assertion must flag it.

Branch resolution:
- prsuccess: every valid entry with (spectag & spectagfix) != 0 gets specbit cleared.
- prmiss: every valid, uncommitted entry with specbit & (spectag & spectagfix) != 0 is invalidated.
  - Stores allocate in program order, so killed entries form the youngest contiguous run.
  - tail rolls back to the oldest killed index; count is reduced accordingly.
- prsuccess and prmiss are never asserted together.

Drain:
- memwe = head.valid & head.committed & ~memoccupy_ld (combinational).
- memaddr = head.addr, memdata = head.data (0 when the buffer is empty).
- When memwe=1: head entry is invalidated and head advances at posedge.
- Exactly one drain per cycle maximum; latency from commit to earliest memwe is 1 cycle.

Forwarding:
- Combinational.
- hitsb=1 when any valid entry (committed or not) has addr == ldaddr, full-width compare.
- lddatasb = data of the youngest matching entry, searched from tail-1 back to head; 0 on miss.
- The entry being allocated in the same cycle is not visible.
- The entry draining in the same cycle is still visible.

Simultaneous events:
- Allocate + drain + commit in one cycle are all honoured; count changes by +1-1 = 0.
- prmiss + drain: drain proceeds, since committed entries are never killed.

Optional Feature:
- Macro: STORE_BUFFER_STATS_EN.
- When defined:
  - Two extra outputs: perf_fwdhit (32 bits) and perf_fullcyc (32 bits).
  - perf_fwdhit counts cycles with hitsb=1; perf_fullcyc counts cycles with fullsb=1.
  - Both saturate at all-ones and clear on reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with stfin=1 asserted -> after reset, count=0, fullsb=0, memwe=0, tail=0.
- Store A=0x100/D=0x11, then B=0x100/D=0x22; ldaddr=0x100 -> hitsb=1, lddatasb=0x22. Then ldaddr=0x104 -> hitsb=0, lddatasb=0.
- Fill 32 non-speculative stores -> fullsb=1 at count 32; 33rd stfin ignored. Then stcom=2 -> memwe on the next two free cycles; fullsb drops after the first drain.
- Store X with specbit=0, then Y and Z with spectag=0b00010/specbit=1; prmiss with spectagfix=0b00010 -> Y and Z invalidated, tail = X+1, ldaddr=Y.addr -> hitsb=0. Repeat with prsuccess -> Y and Z survive with specbit=0.
- Committed head with memoccupy_ld=1 for 3 cycles -> memwe=0 throughout; memwe=1 in the cycle memoccupy_ld drops, with matching memaddr/memdata.
- Wrap-around: 40 allocate/commit/drain cycles with tail crossing index 31->0 -> memory sees writes in allocation order and no entry is lost.
